// File: rtl/demux16_pkg.sv
// Shared types and constants for the demux16_seq serial-to-parallel collector.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package demux16_pkg;

    localparam int SEL_W  = 4;
    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [SEL_W-1:0]  sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_e;

    // Even parity bit of a word: 1 when the word holds an odd number of ones.
    function automatic logic even_par(input word_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/demux16_seq_ctrl.sv
// Control for demux16_seq: mode FSM, AUTO bit counter, word handshake and skid control.
// Latency: all state changes land on the next rising clock edge.
// Backpressure: ready_o drops only in FULL (second word done, first un-acked); en_i=0 freezes beats.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   en_i, valid_i         global enable and beat valid
//   auto_i                AUTO/MANUAL request, acted on in IDLE (and at word boundary in FILL)
//   word_ack_i            consumer acknowledge of word_valid_o
//   ready_o               beat ready
//   word_valid_o          dout holds a complete AUTO word
//   cnt_o                 AUTO bit index
//   man_wr_o              MANUAL write of dout[sel]
//   sh_wr_o               write shadow[cnt] (bits 0..14)
//   ld_direct_o           load dout from shadow + current din (word completes, slot free)
//   skid_wr_o             capture last beat in the skid bit (word completes, slot busy)
//   ld_skid_o             load dout from shadow + skid bit (pending word acked)
import demux16_pkg::*;

module demux16_seq_ctrl (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic valid_i,
    input  logic auto_i,
    input  logic word_ack_i,
    output logic ready_o,
    output logic word_valid_o,
    output sel_t cnt_o,
    output logic man_wr_o,
    output logic sh_wr_o,
    output logic ld_direct_o,
    output logic skid_wr_o,
    output logic ld_skid_o
);

    state_e state_q, state_d;
    sel_t   cnt_q, cnt_d;
    logic   wv_q, wv_d;
    logic   accept;

    // The operating mode is carried by the state itself: IDLE is MANUAL,
    // FILL/FULL are AUTO, so no separate mode flop is kept.
    assign ready_o      = (state_q != FULL);
    assign accept       = valid_i & ready_o & en_i;
    assign word_valid_o = wv_q;
    assign cnt_o        = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wv_q    <= wv_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wv_d        = wv_q;
        man_wr_o    = 1'b0;
        sh_wr_o     = 1'b0;
        ld_direct_o = 1'b0;
        skid_wr_o   = 1'b0;
        ld_skid_o   = 1'b0;

        // Handshake completes independently of en_i; a same-cycle reload below
        // overrides the clear so an acked-and-replaced word stays valid.
        if (wv_q && word_ack_i) begin
            wv_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    if (auto_i) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end else if (accept) begin
                        man_wr_o = 1'b1;
                    end
                end
            end

            FILL: begin
                if (en_i) begin
                    if ((cnt_q == '0) && !auto_i) begin
                        // Mode change honoured only on a word boundary.
                        state_d = IDLE;
                    end else if (accept) begin
                        if (cnt_q == sel_t'(WORD_W - 1)) begin
                            cnt_d = '0;
                            if (!wv_q || word_ack_i) begin
                                ld_direct_o = 1'b1;
                                wv_d        = 1'b1;
                            end else begin
                                skid_wr_o = 1'b1;
                                state_d   = FULL;
                            end
                        end else begin
                            sh_wr_o = 1'b1;
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
            end

            FULL: begin
                // word_valid is necessarily 1 here; the ack swaps in the held word.
                if (word_ack_i) begin
                    ld_skid_o = 1'b1;
                    wv_d      = 1'b1;
                    state_d   = FILL;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/demux16_seq.sv
// Registered 1-to-16 demux / serial-to-parallel collector (MANUAL select or AUTO word assembly).
// Latency: 1 cycle from accepted beat to dout_pad / word_valid_pad update.
// Backpressure: ready_pad=0 only while a second completed word waits behind an un-acked one.
//
// Ports:
//   clk_pad, rst_pad      clock (rising edge), async active-high reset
//   din_pad               serial data bit
//   sel_pad               MANUAL target bit index (ignored in AUTO)
//   en_pad                global enable; 0 blocks every beat
//   auto_pad              1=AUTO sequencer, 0=MANUAL
//   valid_pad / ready_pad beat handshake
//   dout_pad              demuxed word
//   word_valid_pad        AUTO word complete; word_ack_pad acknowledges it
//   cnt_pad               AUTO bit index
// Optional build macro DEMUX16_PARITY_EN adds par_in_pad (parity sent with the
// last beat), parity_pad (registered even parity of dout_pad) and par_err_pad
// (one-cycle pulse when par_in_pad disagrees with the completed word).
import demux16_pkg::*;

module demux16_seq #(
    parameter word_t RST_VAL = 16'h0000
) (
    input  logic        clk_pad,
    input  logic        rst_pad,
    input  logic        din_pad,
    input  logic [3:0]  sel_pad,
    input  logic        en_pad,
    input  logic        auto_pad,
    input  logic        valid_pad,
    output logic        ready_pad,
    output logic [15:0] dout_pad,
    output logic        word_valid_pad,
    input  logic        word_ack_pad,
`ifdef DEMUX16_PARITY_EN
    input  logic        par_in_pad,
    output logic        parity_pad,
    output logic        par_err_pad,
`endif
    output logic [3:0]  cnt_pad
);

    logic man_wr, sh_wr, ld_direct, skid_wr, ld_skid;
    sel_t cnt;

    demux16_seq_ctrl u_ctrl (
        .clk_i        (clk_pad),
        .rst_i        (rst_pad),
        .en_i         (en_pad),
        .valid_i      (valid_pad),
        .auto_i       (auto_pad),
        .word_ack_i   (word_ack_pad),
        .ready_o      (ready_pad),
        .word_valid_o (word_valid_pad),
        .cnt_o        (cnt),
        .man_wr_o     (man_wr),
        .sh_wr_o      (sh_wr),
        .ld_direct_o  (ld_direct),
        .skid_wr_o    (skid_wr),
        .ld_skid_o    (ld_skid)
    );

    assign cnt_pad = cnt;

    // The shadow holds bits 0..14 only: bit 15 is always taken straight from
    // din_pad on the completing beat, or from the skid bit when that beat had
    // to wait for the consumer.
    word_t                   dout_q, dout_d;
    logic  [WORD_W-2:0]      shadow_q, shadow_d;
    logic                    skid_q, skid_d;

    always_comb begin
        dout_d   = dout_q;
        shadow_d = shadow_q;
        skid_d   = skid_q;
        if (man_wr) begin
            dout_d[sel_pad] = din_pad;
        end
        if (sh_wr) begin
            shadow_d[cnt] = din_pad;
        end
        if (skid_wr) begin
            skid_d = din_pad;
        end
        if (ld_direct) begin
            dout_d = {din_pad, shadow_q};
        end
        if (ld_skid) begin
            dout_d = {skid_q, shadow_q};
        end
    end

    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            dout_q   <= RST_VAL;
            shadow_q <= RST_VAL[WORD_W-2:0];
            skid_q   <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            shadow_q <= shadow_d;
            skid_q   <= skid_d;
        end
    end

    assign dout_pad = dout_q;

`ifdef DEMUX16_PARITY_EN
    logic parity_q, par_err_q;

    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            parity_q  <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            parity_q  <= even_par(dout_d);
            // Checked on the completing beat whether the word loads now or waits in skid.
            par_err_q <= (ld_direct | skid_wr) &&
                         (par_in_pad != even_par({din_pad, shadow_q}));
        end
    end

    assign parity_pad  = parity_q;
    assign par_err_pad = par_err_q;
`endif

endmodule

// File: tb/tb_demux16_seq.sv
module tb_demux16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic [3:0]  sel;
    logic        en;
    logic        auto_m;
    logic        valid;
    logic        ready;
    logic [15:0] dout;
    logic        wv;
    logic        ack;
    logic [3:0]  cnt;
`ifdef DEMUX16_PARITY_EN
    logic        par_in;
    logic        parity;
    logic        par_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux16_seq dut (
        .clk_pad        (clk),
        .rst_pad        (rst),
        .din_pad        (din),
        .sel_pad        (sel),
        .en_pad         (en),
        .auto_pad       (auto_m),
        .valid_pad      (valid),
        .ready_pad      (ready),
        .dout_pad       (dout),
        .word_valid_pad (wv),
        .word_ack_pad   (ack),
`ifdef DEMUX16_PARITY_EN
        .par_in_pad     (par_in),
        .parity_pad     (parity),
        .par_err_pad    (par_err),
`endif
        .cnt_pad        (cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mbeat(input logic [3:0] s, input logic d);
        sel = s; din = d; valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    // Stream bits lo..hi of w, LSB first; optionally ack on the final beat.
    task automatic send_bits(input logic [15:0] w, input int lo, input int hi, input logic ack_last);
        for (int i = lo; i <= hi; i++) begin
            din   = w[i];
            valid = 1'b1;
            ack   = ack_last && (i == hi);
            tick();
        end
        valid = 1'b0;
        ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; sel = 4'h0; en = 1'b0; auto_m = 1'b0;
        valid = 1'b0; ack = 1'b0;
`ifdef DEMUX16_PARITY_EN
        par_in = 1'b0;
`endif
        #3;
        chk("rst_dout",  dout,          16'h0000);
        chk("rst_wv",    16'(wv),       16'h0);
        chk("rst_cnt",   16'(cnt),      16'h0);
        chk("rst_ready", 16'(ready),    16'h1);
        rst = 1'b0;
        en  = 1'b1;

        // MANUAL mode
        mbeat(4'd0, 1'b1);
        mbeat(4'd5, 1'b1);
        chk("man_2", dout, 16'h0021);
        mbeat(4'd15, 1'b1);
        mbeat(4'd5, 1'b0);
        chk("man_4",     dout,       16'h8001);
        chk("man_ready", 16'(ready), 16'h1);
        chk("man_wv",    16'(wv),    16'h0);

        // AUTO mode: one idle cycle to enter FILL, then stream A5C3
        auto_m = 1'b1;
        sel    = 4'hF;
        tick();
        chk("fill_cnt0", 16'(cnt), 16'h0);
        send_bits(16'hA5C3, 0, 14, 1'b0);
        chk("a_pre_cnt",  16'(cnt), 16'd15);
        chk("a_pre_wv",   16'(wv),  16'h0);
        chk("a_pre_dout", dout,     16'h8001);
        send_bits(16'hA5C3, 15, 15, 1'b0);
        chk("a_dout", dout,     16'hA5C3);
        chk("a_wv",   16'(wv),  16'h1);
        chk("a_cnt",  16'(cnt), 16'h0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("a_ack_wv",   16'(wv), 16'h0);
        chk("a_ack_dout", dout,    16'hA5C3);

        // en_pad=0 for three cycles at cnt=7
        send_bits(16'h5A3C, 0, 6, 1'b0);
        chk("en_cnt7", 16'(cnt), 16'd7);
        en = 1'b0; valid = 1'b1; din = 1'b1;
        tick(); tick(); tick();
        valid = 1'b0;
        chk("en_frozen", 16'(cnt),   16'd7);
        chk("en_ready",  16'(ready), 16'h1);
        en = 1'b1;
        send_bits(16'h5A3C, 7, 15, 1'b0);
        chk("en_dout", dout,    16'h5A3C);
        chk("en_wv",   16'(wv), 16'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Back-to-back words without ack
        send_bits(16'h1234, 0, 15, 1'b0);
        chk("b1_dout", dout, 16'h1234);
        send_bits(16'hFFFF, 0, 15, 1'b0);
        chk("b2_ready", 16'(ready), 16'h0);
        chk("b2_dout",  dout,       16'h1234);
        chk("b2_wv",    16'(wv),    16'h1);
        valid = 1'b1; din = 1'b0;
        tick();
        valid = 1'b0;
        chk("full_hold_cnt",  16'(cnt), 16'h0);
        chk("full_hold_dout", dout,     16'h1234);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("full_ack_dout",  dout,       16'hFFFF);
        chk("full_ack_wv",    16'(wv),    16'h1);
        chk("full_ack_ready", 16'(ready), 16'h1);

        // Ack on the completing beat of the next word
        send_bits(16'h0F0F, 0, 15, 1'b1);
        chk("sim_dout",  dout,       16'h0F0F);
        chk("sim_wv",    16'(wv),    16'h1);
        chk("sim_ready", 16'(ready), 16'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("sim_ack_wv", 16'(wv), 16'h0);

        // Asynchronous reset at cnt=9
        send_bits(16'hC3A5, 0, 8, 1'b0);
        chk("r_cnt9", 16'(cnt), 16'd9);
        #2 rst = 1'b1;
        #1;
        chk("r_dout", dout,     16'h0000);
        chk("r_wv",   16'(wv),  16'h0);
        chk("r_cnt",  16'(cnt), 16'h0);
        #2 rst = 1'b0;
        tick();
        send_bits(16'h3C96, 0, 15, 1'b0);
        chk("r_word_dout", dout,    16'h3C96);
        chk("r_word_wv",   16'(wv), 16'h1);

        // Leave AUTO at a word boundary, then a MANUAL write
        auto_m = 1'b0;
        ack    = 1'b1;
        tick();
        ack    = 1'b0;
        chk("back_wv", 16'(wv), 16'h0);
        mbeat(4'd3, 1'b1);
        chk("back_man_dout", dout,     16'h3C9E);
        chk("back_man_cnt",  16'(cnt), 16'h0);

`ifdef DEMUX16_PARITY_EN
        // 16'h0001 has odd weight; par_in=0 disagrees
        auto_m = 1'b1;
        par_in = 1'b0;
        tick();
        send_bits(16'h0001, 0, 15, 1'b0);
        chk("par_dout", dout,         16'h0001);
        chk("par_bit",  16'(parity),  16'h1);
        chk("par_err",  16'(par_err), 16'h1);
        tick();
        chk("par_err_clr", 16'(par_err), 16'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
